// File: rtl/store_buffer_if.sv
// store_buffer_if: memory-stage request/response and SRAM-controller signals of the store buffer.
interface store_buffer_if;
  logic        wr_req;
  logic        rd_req;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        rdy;
  logic [31:0] rd_data;
  logic        sram_wr_en;
  logic        sram_rd_en;
  logic [31:0] sram_addr;
  logic [31:0] sram_wr_data;
  logic        sram_rdy;
  logic [63:0] sram_rd_data;
  logic        full;
  logic        empty;
  modport master (
    output wr_req, rd_req, addr, wr_data, sram_rdy, sram_rd_data,
    input  rdy, rd_data, sram_wr_en, sram_rd_en, sram_addr, sram_wr_data, full, empty
  );
  modport slave (
    input  wr_req, rd_req, addr, wr_data, sram_rdy, sram_rd_data,
    output rdy, rd_data, sram_wr_en, sram_rd_en, sram_addr, sram_wr_data, full, empty
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: circular store FIFO drained to SRAM; loads go to SRAM via READ, prioritised over drains.
// Define STORE_BUFFER_FWD_EN to return the youngest matching buffered store to a load in the same cycle.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, idx;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic          push, pop, rd_done, match, fwd_hit;
  logic [31:0]   match_data;
  // Scan oldest to youngest so the last hit wins.
  always_comb begin
    match = 1'b0;
    match_data = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q && addr_q[idx][31:2] == bus.addr[31:2]) begin
        match = 1'b1;
        match_data = data_q[idx];
      end
    end
  end
`ifdef STORE_BUFFER_FWD_EN
  assign fwd_hit = bus.rd_req && match;
`else
  assign fwd_hit = 1'b0;
`endif
  always_comb begin
    push = bus.wr_req && !bus.rd_req && count_q != CW'(DEPTH);
    pop = state_q == DRAIN && bus.sram_rdy;
    rd_done = state_q == READ && bus.sram_rdy;
    head_d = pop ? head_q + PW'(1) : head_q;
    tail_d = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    addr_d = addr_q;
    data_d = data_q;
    if (push) begin
      addr_d[tail_q] = bus.addr;
      data_d[tail_q] = bus.wr_data;
    end
    // A matching load without forwarding falls through to DRAIN until the match is gone.
    state_d = state_q == IDLE  ? (bus.rd_req && !match ? READ : count_q != '0 ? DRAIN : IDLE)
            : state_q == DRAIN ? (pop ? IDLE : DRAIN)
            : state_q == READ && !bus.sram_rdy ? READ : IDLE;
  end
  always_comb begin
    bus.rdy = push || fwd_hit || rd_done;
    bus.rd_data = fwd_hit ? match_data
                : rd_done ? (bus.addr[2] ? bus.sram_rd_data[63:32] : bus.sram_rd_data[31:0]) : '0;
    bus.sram_wr_en = state_q == DRAIN;
    bus.sram_rd_en = state_q == READ;
    bus.sram_addr = state_q == DRAIN ? addr_q[head_q] : state_q == READ ? bus.addr : '0;
    bus.sram_wr_data = state_q == DRAIN ? data_q[head_q] : '0;
    bus.full = count_q == CW'(DEPTH);
    bus.empty = count_q == '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: store buffer bench with an SRAM responder model and a load-result scoreboard.
module tb_store_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  store_buffer_if sb();
  store_buffer #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(sb.slave));
  typedef struct {
    bit          ld;
    logic [31:0] a;
    logic [31:0] d;
    int          lat;
  } vec_t;
  int errors = 0;
  int checks = 0;
  int w, n0, n;
  bit done;
  logic sram_hold = 1'b0;
  int sram_lat = 0;
  int wait_cnt = 0;
  int rd_en_cycles = 0;
  logic [31:0] sram_mem [logic [29:0]];
  logic [31:0] wr_log_a [$];
  logic [31:0] wr_log_d [$];
  logic [31:0] exp_q [$];
  vec_t tbl [10];
  function automatic logic [31:0] dflt(input logic [29:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : dflt(a);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // SRAM controller model: completes a beat sram_lat cycles after the request appears.
  initial begin
    sb.sram_rdy = 1'b0;
    sb.sram_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst || sb.sram_rdy) begin
        sb.sram_rdy = 1'b0;
        wait_cnt = 0;
      end else if ((sb.sram_wr_en || sb.sram_rd_en) && !sram_hold) begin
        if (wait_cnt >= sram_lat) begin
          sb.sram_rdy = 1'b1;
          if (sb.sram_wr_en) begin
            sram_mem[sb.sram_addr[31:2]] = sb.sram_wr_data;
            wr_log_a.push_back(sb.sram_addr);
            wr_log_d.push_back(sb.sram_wr_data);
          end else begin
            sb.sram_rd_data = {mem_rd({sb.sram_addr[31:3], 1'b1}), mem_rd({sb.sram_addr[31:3], 1'b0})};
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end
  always @(negedge clk) if (sb.sram_rd_en) rd_en_cycles++;
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    sb.wr_req = 1'b1;
    sb.addr = a;
    sb.wr_data = d;
    while (!ok && waited < 300) begin
      @(negedge clk);
      if (sb.rdy) ok = 1'b1;
      else waited++;
      step();
    end
    sb.wr_req = 1'b0;
    chk($sformatf("store_%0h_done", a), 32'(ok), 1);
  endtask
  task automatic do_load(input logic [31:0] a, input logic [31:0] exp, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    exp_q.push_back(exp);
    sb.rd_req = 1'b1;
    sb.addr = a;
    while (!ok && waited < 300) begin
      @(negedge clk);
      if (sb.rdy) begin
        ok = 1'b1;
        chk($sformatf("load_%0h_data", a), sb.rd_data, exp_q.pop_front());
      end else begin
        waited++;
      end
      step();
    end
    sb.rd_req = 1'b0;
    if (!ok) void'(exp_q.pop_front());
    chk($sformatf("load_%0h_done", a), 32'(ok), 1);
  endtask
  task automatic wait_drained();
    int k;
    k = 0;
    while (!(sb.empty && !sb.sram_wr_en) && k < 500) begin
      step();
      k++;
    end
    chk("drained", 32'(sb.empty), 1);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{1'b0, 32'h600, 32'h1, 0};
    tbl[1] = '{1'b0, 32'h604, 32'h2, 2};
    tbl[2] = '{1'b1, 32'h600, 32'h1, 1};
    tbl[3] = '{1'b0, 32'h608, 32'h3, 3};
    tbl[4] = '{1'b1, 32'h604, 32'h2, 0};
    tbl[5] = '{1'b1, 32'h60C, 32'h0183_FE7C, 2};
    tbl[6] = '{1'b0, 32'h600, 32'h4, 1};
    tbl[7] = '{1'b1, 32'h600, 32'h4, 0};
    tbl[8] = '{1'b1, 32'h700, 32'h01C0_FE3F, 4};
    tbl[9] = '{1'b1, 32'h608, 32'h3, 1};
    sb.wr_req = 1'b0;
    sb.rd_req = 1'b0;
    sb.addr = '0;
    sb.wr_data = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_wr_en", 32'(sb.sram_wr_en), 0);
    chk("rst_rd_en", 32'(sb.sram_rd_en), 0);
    chk("rst_sram_addr", sb.sram_addr, 0);
    chk("rst_sram_wr_data", sb.sram_wr_data, 0);
    chk("rst_full", 32'(sb.full), 0);
    chk("rst_empty", 32'(sb.empty), 1);
    chk("rst_rdy", 32'(sb.rdy), 0);
    chk("rst_rd_data", sb.rd_data, 0);
    step();
    rst = 1'b1;
    step();
    // Fill with SRAM stalled, then a fifth store waits for the first drain beat.
    sram_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), w);
      chk("fill_rdy_same_cycle", w, 0);
    end
    chk("full_after_fill", 32'(sb.full), 1);
    chk("empty_after_fill", 32'(sb.empty), 0);
    sb.wr_req = 1'b1;
    sb.addr = 32'h110;
    sb.wr_data = 32'hA4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_store_rdy", 32'(sb.rdy), 0);
      chk("drain_head_addr", sb.sram_addr, 32'h100);
      step();
    end
    chk("drain_head_data", sb.sram_wr_data, 32'hA0);
    chk("drain_wr_en", 32'(sb.sram_wr_en), 1);
    sram_lat = 0;
    sram_hold = 1'b0;
    done = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      if (sb.rdy) begin
        done = 1'b1;
        chk("push_after_pop_cycle", 32'(sb.sram_rdy), 0);
        chk("pops_before_fifth", wr_log_a.size(), 1);
      end
      n++;
      step();
    end
    sb.wr_req = 1'b0;
    chk("fifth_store_done", 32'(done), 1);
    sram_lat = 1;
    wait_drained();
    chk("fill_write_count", wr_log_a.size(), 5);
    for (int i = 0; i < 5 && i < wr_log_a.size(); i++) begin
      chk("fill_write_addr", wr_log_a[i], 32'h100 + 32'(4 * i));
      chk("fill_write_data", wr_log_d[i], 32'hA0 + 32'(i));
    end
    // Empty-buffer load: upper and lower word of the SRAM doubleword.
    sram_mem[30'hC1] = 32'h1234_5678;
    sram_mem[30'hC0] = 32'h9ABC_DEF0;
    sram_lat = 5;
    n0 = rd_en_cycles;
    do_load(32'h304, 32'h1234_5678, w);
    chk("read_waits_for_sram", 32'(w >= 5), 1);
    chk("read_used_sram", 32'(rd_en_cycles > n0), 1);
    do_load(32'h300, 32'h9ABC_DEF0, w);
    // Two stores to one word, then a load of it.
    wr_log_a.delete();
    wr_log_d.delete();
    sram_hold = 1'b1;
    sram_lat = 1;
    do_store(32'h200, 32'h11, w);
    do_store(32'h200, 32'h22, w);
    n0 = rd_en_cycles;
`ifdef STORE_BUFFER_FWD_EN
    do_load(32'h200, 32'h22, w);
    chk("fwd_same_cycle", w, 0);
    chk("fwd_no_sram_read", rd_en_cycles - n0, 0);
    sram_hold = 1'b0;
    wait_drained();
`else
    fork
      do_load(32'h200, 32'h22, w);
      begin
        repeat (3) step();
        sram_hold = 1'b0;
      end
    join
    chk("match_stalls", 32'(w >= 3), 1);
    chk("match_drained_count", wr_log_a.size(), 2);
    if (wr_log_d.size() == 2) begin
      chk("match_drain_first", wr_log_d[0], 32'h11);
      chk("match_drain_second", wr_log_d[1], 32'h22);
    end
    chk("match_then_sram_read", 32'(rd_en_cycles > n0), 1);
`endif
    // Load arriving mid-drain is served right after the current beat.
    wr_log_a.delete();
    wr_log_d.delete();
    sram_hold = 1'b1;
    do_store(32'h100, 32'hB0, w);
    do_store(32'h104, 32'hB1, w);
    do_store(32'h108, 32'hB2, w);
    chk("mid_drain_addr", sb.sram_addr, 32'h100);
    fork
      do_load(32'h400, 32'h0100_FEFF, w);
      begin
        repeat (2) step();
        sram_hold = 1'b0;
      end
    join
    chk("read_after_one_beat", wr_log_a.size(), 1);
    wait_drained();
    chk("drain_rest_count", wr_log_a.size(), 3);
    if (wr_log_a.size() == 3) begin
      chk("drain_order_0", wr_log_a[0], 32'h100);
      chk("drain_order_1", wr_log_a[1], 32'h104);
      chk("drain_order_2", wr_log_a[2], 32'h108);
    end
    for (int i = 0; i < 10; i++) begin
      sram_lat = tbl[i].lat;
      if (tbl[i].ld) do_load(tbl[i].a, tbl[i].d, w);
      else do_store(tbl[i].a, tbl[i].d, w);
    end
    wait_drained();
    // Reset in the middle of a drain discards everything buffered.
    wr_log_a.delete();
    wr_log_d.delete();
    sram_hold = 1'b1;
    do_store(32'h500, 32'hC0, w);
    do_store(32'h504, 32'hC1, w);
    step();
    @(negedge clk);
    chk("pre_rst_wr_en", 32'(sb.sram_wr_en), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(sb.sram_wr_en), 0);
    chk("mid_rst_empty", 32'(sb.empty), 1);
    chk("mid_rst_full", 32'(sb.full), 0);
    chk("mid_rst_sram_addr", sb.sram_addr, 0);
    step();
    step();
    rst = 1'b1;
    sram_hold = 1'b0;
    sram_lat = 2;
    n0 = rd_en_cycles;
    do_load(32'h500, 32'h0140_FEBF, w);
    chk("post_rst_load_sram", 32'(rd_en_cycles > n0), 1);
    chk("post_rst_no_writes", wr_log_a.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
